// File: rtl/core_mem_arb_pkg.sv
// Shared definitions for the core memory arbiter: arbitration mode codes
// and the two-state transaction FSM encoding.
package core_mem_arb_pkg;

    localparam int ARB_MODE_FIXED = 0;
    localparam int ARB_MODE_RR    = 1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/core_mem_arb_pick.sv
// Combinational priority picker: first set request at or after the search
// base (ptr in round-robin mode, 0 in fixed mode), with wrap-around.
module core_mem_arb_pick #(
    parameter int CHANNELS = 2,
    parameter int IDX_W    = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    input  logic                rr_mode,
    output logic [IDX_W-1:0]    winner,
    output logic                any
);

    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0]    base;
    logic [SUM_W-1:0]    sum;
    logic [CHANNELS-1:0] rot;

    always_comb begin
        base = rr_mode ? {1'b0, ptr} : '0;
        // Rotate so the search base lands at bit 0; lowest set bit then wins.
        rot  = CHANNELS'({req, req} >> base);
        sum  = base;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = base + SUM_W'(i);
            end
        end
        if (sum >= SUM_W'(CHANNELS)) begin
            sum = sum - SUM_W'(CHANNELS);
        end
        winner = sum[IDX_W-1:0];
        any    = |req;
    end

endmodule

// File: rtl/core_mem_arb.sv
// N-channel core memory arbiter. The winner drives the downstream port in
// the same cycle; the channel stays locked until the downstream response.
module core_mem_arb
    import core_mem_arb_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MODE     = 1
) (
    input  logic                         g_clk,
    input  logic                         g_resetn,
    input  logic [CHANNELS-1:0]          s_req,
    input  logic [CHANNELS*ADDR_W-1:0]   s_addr,
    input  logic [CHANNELS-1:0]          s_wen,
    input  logic [CHANNELS*DATA_W/8-1:0] s_strb,
    input  logic [CHANNELS*DATA_W-1:0]   s_wdata,
    output logic [CHANNELS-1:0]          s_gnt,
    output logic [CHANNELS-1:0]          s_err,
    output logic [DATA_W-1:0]            s_rdata,
    output logic                         m_req,
    output logic [ADDR_W-1:0]            m_addr,
    output logic                         m_wen,
    output logic [DATA_W/8-1:0]          m_strb,
    output logic [DATA_W-1:0]            m_wdata,
    input  logic                         m_gnt,
    input  logic                         m_err,
    input  logic [DATA_W-1:0]            m_rdata,
    output logic [$clog2(CHANNELS)-1:0]  owner
);

    localparam int   IDX_W   = $clog2(CHANNELS);
    localparam int   STRB_W  = DATA_W / 8;
    localparam logic RR_MODE = (MODE == ARB_MODE_RR);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] sel;
    logic             any;
    logic             owner_req;
    logic             fire;

    core_mem_arb_pick #(
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_pick (
        .req     (s_req),
        .ptr     (rr_ptr_q),
        .rr_mode (RR_MODE),
        .winner  (winner),
        .any     (any)
    );

    always_comb begin
        owner_req = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_req = s_req[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        sel      = owner_q;
        m_req    = 1'b0;
        fire     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (any) begin
                    sel     = winner;
                    owner_d = winner;
                    m_req   = 1'b1;
                    if (m_gnt) begin
                        fire = 1'b1;
                    end else begin
                        state_d = ARB_BUSY;
                    end
                end
            end
            ARB_BUSY: begin
                // A dropped request lowers m_req but keeps the lock until m_gnt.
                m_req = owner_req;
                if (m_gnt) begin
                    fire    = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (fire && RR_MODE) begin
            rr_ptr_d = (sel == IDX_W'(CHANNELS - 1)) ? '0 : sel + IDX_W'(1);
        end
        if (!g_resetn) begin
            sel   = '0;
            m_req = 1'b0;
            fire  = 1'b0;
        end
    end

    always_comb begin
        m_addr  = '0;
        m_wen   = 1'b0;
        m_strb  = '0;
        m_wdata = '0;
        s_gnt   = '0;
        s_err   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == IDX_W'(i)) begin
                m_addr   = s_addr[i*ADDR_W +: ADDR_W];
                m_wen    = s_wen[i];
                m_strb   = s_strb[i*STRB_W +: STRB_W];
                m_wdata  = s_wdata[i*DATA_W +: DATA_W];
                s_gnt[i] = fire;
                s_err[i] = fire & m_err;
            end
        end
    end

    assign s_rdata = m_rdata;
    assign owner   = sel;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
